// File: rtl/int_pow_pkg.sv
// Shared definitions for the iterative integer power engine:
// FSM state encoding and the default operand width.
package int_pow_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/int_pow_engine_mul.sv
// Combinational WIDTH x WIDTH unsigned multiply: low half of the product
// plus a flag that the discarded upper half was nonzero.
module pow_mul_ovf #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic             hi_nz
);

  logic [2*WIDTH-1:0] prod;

  assign prod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign lo    = prod[WIDTH-1:0];
  assign hi_nz = |prod[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/int_pow_engine.sv
// Square-and-multiply power engine: one exponent bit per clock, saturating
// result with a sticky overflow flag, start/done handshake.
module int_pow_engine
  import int_pow_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] expo,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only in IDLE; base/expo are captured on that
  // edge. done is a one-cycle pulse and result/overflow are valid with it,
  // holding afterwards until the next accepted start completes.

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] e_reg;
  logic             acc_ovf;
  logic             b_ovf;

  logic [WIDTH-1:0] mul_lo;
  logic             mul_hi_nz;
  logic [WIDTH-1:0] sq_lo;
  logic             sq_hi_nz;

  logic [WIDTH-1:0] acc_nx;
  logic             acc_ovf_nx;
  logic [WIDTH-1:0] e_nx;

  pow_mul_ovf #(.WIDTH(WIDTH)) u_acc_mul (
    .a     (acc),
    .b     (b_reg),
    .lo    (mul_lo),
    .hi_nz (mul_hi_nz)
  );

  pow_mul_ovf #(.WIDTH(WIDTH)) u_sq_mul (
    .a     (b_reg),
    .b     (b_reg),
    .lo    (sq_lo),
    .hi_nz (sq_hi_nz)
  );

  // A squared base that overflowed only poisons acc once it is multiplied in.
  assign acc_nx     = e_reg[0] ? mul_lo : acc;
  assign acc_ovf_nx = acc_ovf | (e_reg[0] & (mul_hi_nz | b_ovf));
  assign e_nx       = e_reg >> 1;
  assign dbg_state  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      result   <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc      <= {{(WIDTH-1){1'b0}}, 1'b1};
      b_reg    <= '0;
      e_reg    <= '0;
      acc_ovf  <= 1'b0;
      b_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc     <= {{(WIDTH-1){1'b0}}, 1'b1};
            acc_ovf <= 1'b0;
            if (expo == '0) begin
              result   <= {{(WIDTH-1){1'b0}}, 1'b1};
              overflow <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              b_reg <= base;
              e_reg <= expo;
              b_ovf <= 1'b0;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc     <= acc_nx;
          acc_ovf <= acc_ovf_nx;
          b_reg   <= sq_lo;
          b_ovf   <= b_ovf | sq_hi_nz;
          e_reg   <= e_nx;
          if (e_nx == '0) begin
            result   <= acc_ovf_nx ? {WIDTH{1'b1}} : acc_nx;
            overflow <= acc_ovf_nx;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_pow_engine.sv
// Bench for int_pow_engine: directed corner cases plus random operands,
// compared against a plain repeated-multiply reference.
module tb_int_pow_engine;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] base;
  logic [W-1:0] expo;
  logic [W-1:0] result;
  logic         overflow;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  int checks;
  int failures;
  logic [W-1:0] exp_q[$];

  int_pow_engine #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .expo      (expo),
    .result    (result),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // True power by repeated multiplication, saturating once it exceeds 2^W-1.
  function automatic void ref_pow(input int unsigned b, input int unsigned e,
                                  output logic [W-1:0] r, output logic o,
                                  output int k);
    longint unsigned p;
    p = 1;
    o = 1'b0;
    for (int unsigned i = 0; i < e && !o; i++) begin
      p = p * b;
      if (p > 65535) o = 1'b1;
    end
    r = o ? 16'hFFFF : p[W-1:0];
    k = 0;
    for (int i = 0; i < W; i++) if (e[i]) k = i + 1;
  endfunction

  task automatic do_op(input string tag, input logic [W-1:0] b,
                       input logic [W-1:0] e, input bit poke);
    logic [W-1:0] exp_r;
    logic [W-1:0] prev_r;
    logic         exp_o;
    logic         prev_o;
    logic         held;
    int           k;
    int           edges;
    int           busy_cycles;
    ref_pow(b, e, exp_r, exp_o, k);
    exp_q.push_back(exp_r);
    prev_r = result;
    prev_o = overflow;
    held   = 1'b1;
    @(negedge clk);
    base  = b;
    expo  = e;
    start = 1'b1;
    @(posedge clk);
    edges       = 1;
    busy_cycles = 0;
    #1;
    start = 1'b0;
    base  = W'($urandom);
    expo  = W'($urandom);
    while (!done && edges < 40) begin
      if (busy) busy_cycles++;
      if (busy && (result !== prev_r || overflow !== prev_o)) held = 1'b0;
      if (poke && edges == 5) start = 1'b1;
      @(posedge clk);
      edges++;
      #1;
      start = 1'b0;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_latency"}, edges, k + 1);
    check({tag, "_busy_cycles"}, busy_cycles, k);
    check({tag, "_hold_in_run"}, held, 1);
    check({tag, "_result"}, result, exp_q.pop_front());
    check({tag, "_overflow"}, overflow, exp_o);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_result_hold"}, result, exp_r);
    check({tag, "_state_idle"}, dbg_state, 0);
  endtask

  initial begin
    logic [W-1:0] rb;
    logic [W-1:0] re;
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b0;
    base  = '0;
    expo  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", result, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;

    do_op("pow_3_5", 16'd3, 16'd5, 1'b0);
    do_op("pow_0_0", 16'd0, 16'd0, 1'b0);
    do_op("pow_7_0", 16'd7, 16'd0, 1'b0);
    do_op("pow_2_15", 16'd2, 16'd15, 1'b0);
    do_op("pow_2_16", 16'd2, 16'd16, 1'b0);
    do_op("pow_256_1", 16'd256, 16'd1, 1'b0);
    do_op("pow_256_2", 16'd256, 16'd2, 1'b0);
    do_op("pow_1_ffff", 16'd1, 16'hFFFF, 1'b1);
    do_op("pow_0_9", 16'd0, 16'd9, 1'b0);
    do_op("pow_255_2", 16'd255, 16'd2, 1'b0);

    // Asynchronous reset two cycles into RUN, between clock edges.
    @(negedge clk);
    base  = 16'd3;
    expo  = 16'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_result", result, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
    do_op("pow_5_3", 16'd5, 16'd3, 1'b0);

    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) begin
        rb = W'($urandom);
        re = W'($urandom_range(0, 4));
      end else begin
        rb = W'($urandom_range(0, 24));
        re = W'($urandom_range(0, 20));
      end
      do_op($sformatf("rand%0d", i), rb, re, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
